// File: rtl/btb_update_arbiter.sv
// btb_update_arbiter
//   Sole write master of the BTB. Mispredicted control-flow updates from EX are
//   filtered, coalesced and queued in a small FIFO, then round-robined against a
//   debug/preload port. A clear sweep rewrites every BTB index so that every hit
//   predicts PC+4.
//
// Ports
//   clk, rst_n              clock (posedge), asynchronous active-low reset
//   upd_valid/pc/npc/       EX resolution: PC, actual NPC and the NPC predicted at
//   upd_npc_pred            fetch; only mispredicts with aligned PCs are queued
//   upd_ready               queue can accept (not full, not sweeping)
//   dbg_valid/pc/npc        debug write request, held until dbg_ready
//   dbg_ready               debug request granted this cycle
//   sweep_req               start a clear sweep (level, sampled at posedge)
//   sweep_busy              sweep in progress
//   btb_we/btb_pc/btb_npc   registered BTB write port
//   drop_cnt                saturating count of lost mispredict updates
module btb_update_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int INDEX_BITS = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd_valid,
    input  logic [15:0]      upd_pc,
    input  logic [15:0]      upd_npc,
    input  logic [15:0]      upd_npc_pred,
    output logic             upd_ready,
    input  logic             dbg_valid,
    input  logic [15:0]      dbg_pc,
    input  logic [15:0]      dbg_npc,
    output logic             dbg_ready,
    input  logic             sweep_req,
    output logic             sweep_busy,
    output logic             btb_we,
    output logic [15:0]      btb_pc,
    output logic [15:0]      btb_npc,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t            state;
    logic [15:0]       q_pc  [FIFO_DEPTH];
    logic [15:0]       q_npc [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;
    logic              rr_last_dbg;   // 1: debug won the most recent grant
    logic [INDEX_BITS:0] sweep_idx;   // next index to write; MSB set = sweep done

    logic             sweeping;
    logic             sweep_start;
    logic             fifo_pend;
    logic             cand;
    logic [PTR_W-1:0] tail_ptr;
    logic             grant_fifo;
    logic             grant_dbg;
    logic             tail_popped;
    logic             coalesce;
    logic             push;
    logic             drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [15:0] sweep_pc(input logic [INDEX_BITS-1:0] idx);
        return 16'(idx) << 2;
    endfunction

    assign sweeping    = (state == SWEEP);
    assign sweep_start = !sweeping && sweep_req;
    assign fifo_pend   = (count != '0);
    assign tail_ptr    = wr_ptr - PTR_W'(1);

    // Only mispredicted, word-aligned control flow is worth a BTB write.
    assign cand = upd_valid && (upd_npc != upd_npc_pred) && (upd_pc[1:0] == 2'b00);

    // Grant is decided from current occupancy so a freshly queued entry can be
    // written on the very next edge; a starting sweep suppresses all grants.
    always_comb begin
        grant_fifo = 1'b0;
        grant_dbg  = 1'b0;
        if (!sweeping && !sweep_req) begin
            if (fifo_pend && dbg_valid) begin
                if (rr_last_dbg) grant_fifo = 1'b1;
                else             grant_dbg  = 1'b1;
            end else if (fifo_pend) begin
                grant_fifo = 1'b1;
            end else if (dbg_valid) begin
                grant_dbg = 1'b1;
            end
        end
    end

    // The tail can only be overwritten if it is not leaving the queue this cycle.
    assign tail_popped = grant_fifo && (count == (PTR_W+1)'(1));
    assign coalesce    = cand && fifo_pend && !tail_popped && (q_pc[tail_ptr] == upd_pc);

    // Ready is evaluated before any pop, so a push into a full queue is lost even
    // when an entry drains in the same cycle.
    assign upd_ready = (count < DEPTH) && !sweeping;
    assign dbg_ready = grant_dbg;
    assign push      = cand && upd_ready && !coalesce;
    assign drop      = cand && !upd_ready && !coalesce;

    always_comb begin
        count_next = count;
        if (push && !grant_fifo)      count_next = count + (PTR_W+1)'(1);
        else if (!push && grant_fifo) count_next = count - (PTR_W+1)'(1);
    end

    // Queue storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]  <= upd_pc;
            q_npc[wr_ptr] <= upd_npc;
        end else if (coalesce) begin
            q_npc[tail_ptr] <= upd_npc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            rr_last_dbg <= 1'b0;
            sweep_idx   <= '0;
            sweep_busy  <= 1'b0;
            btb_we      <= 1'b0;
            btb_pc      <= '0;
            btb_npc     <= '0;
            drop_cnt    <= '0;
        end else begin
            if (drop) drop_cnt <= sat_inc(drop_cnt);

            if (sweep_start) begin
                // Flush pending EX work and issue index 0 right away.
                state      <= SWEEP;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
                sweep_busy <= 1'b1;
                sweep_idx  <= (INDEX_BITS+1)'(1);
                btb_we     <= 1'b1;
                btb_pc     <= sweep_pc('0);
                btb_npc    <= sweep_pc('0) + 16'd4;
            end else if (sweeping) begin
                if (sweep_idx[INDEX_BITS]) begin
                    state      <= IDLE;
                    sweep_busy <= 1'b0;
                    btb_we     <= 1'b0;
                end else begin
                    btb_we    <= 1'b1;
                    btb_pc    <= sweep_pc(sweep_idx[INDEX_BITS-1:0]);
                    btb_npc   <= sweep_pc(sweep_idx[INDEX_BITS-1:0]) + 16'd4;
                    sweep_idx <= sweep_idx + (INDEX_BITS+1)'(1);
                end
            end else begin
                btb_we <= grant_fifo || grant_dbg;
                if (grant_fifo) begin
                    btb_pc      <= q_pc[rd_ptr];
                    btb_npc     <= q_npc[rd_ptr];
                    rd_ptr      <= rd_ptr + PTR_W'(1);
                    rr_last_dbg <= 1'b0;
                end else if (grant_dbg) begin
                    btb_pc      <= dbg_pc;
                    btb_npc     <= dbg_npc;
                    rr_last_dbg <= 1'b1;
                end
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                count <= count_next;
                state <= ((count_next != '0) || (dbg_valid && !grant_dbg)) ? SERVE : IDLE;
            end
        end
    end

endmodule

// File: tb/tb_btb_update_arbiter.sv
// tb_btb_update_arbiter
//   Scenario-driven bench for btb_update_arbiter. Each scenario pushes the BTB
//   writes it expects onto a scoreboard queue; a negedge monitor pops and
//   compares every btb_we pulse. Scenario tasks also compare control outputs.
module tb_btb_update_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_pc = '0;
    logic [15:0] upd_npc = '0;
    logic [15:0] upd_npc_pred = '0;
    logic        upd_ready;
    logic        dbg_valid = 1'b0;
    logic [15:0] dbg_pc = '0;
    logic [15:0] dbg_npc = '0;
    logic        dbg_ready;
    logic        sweep_req = 1'b0;
    logic        sweep_busy;
    logic        btb_we;
    logic [15:0] btb_pc;
    logic [15:0] btb_npc;
    logic [15:0] drop_cnt;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] npc;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_drop = 0;

    btb_update_arbiter #(.FIFO_DEPTH(4), .INDEX_BITS(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_npc(upd_npc),
        .upd_npc_pred(upd_npc_pred), .upd_ready(upd_ready),
        .dbg_valid(dbg_valid), .dbg_pc(dbg_pc), .dbg_npc(dbg_npc), .dbg_ready(dbg_ready),
        .sweep_req(sweep_req), .sweep_busy(sweep_busy),
        .btb_we(btb_we), .btb_pc(btb_pc), .btb_npc(btb_npc), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && btb_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got pc=%h npc=%h want no write", btb_pc, btb_npc);
            end else begin
                e = exp_q.pop_front();
                if (btb_pc !== e.pc || btb_npc !== e.npc) begin
                    errors++;
                    $display("FAIL btb_write got pc=%h npc=%h want pc=%h npc=%h",
                             btb_pc, btb_npc, e.pc, e.npc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] pc, input logic [15:0] npc);
        wr_t e;
        e.pc  = pc;
        e.npc = npc;
        exp_q.push_back(e);
    endtask

    task automatic drive_upd(input logic [15:0] pc, input logic [15:0] npc,
                             input logic [15:0] pred);
        upd_valid    = 1'b1;
        upd_pc       = pc;
        upd_npc      = npc;
        upd_npc_pred = pred;
    endtask

    // Waits (bounded) for the scoreboard to empty, then idles a few cycles so
    // any stray write is caught by the monitor.
    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (btb_we !== 1'b0 || btb_pc !== 16'h0 || btb_npc !== 16'h0) begin
            errors++;
            $display("FAIL reset_btb got we=%b pc=%h npc=%h want 0 0 0", btb_we, btb_pc, btb_npc);
        end
        checks++;
        if (sweep_busy !== 1'b0 || drop_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b drop=%0d want 0 0", sweep_busy, drop_cnt);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (upd_ready !== 1'b1 || dbg_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got upd_ready=%b dbg_ready=%b want 1 0", upd_ready, dbg_ready);
        end
    endtask

    task automatic test_single_update();
        bit ok;
        push_exp(16'h0040, 16'h0100);
        drive_upd(16'h0040, 16'h0100, 16'h0044);
        step();
        upd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (btb_we !== 1'b0) begin
            errors++;
            $display("FAIL single_we_early got %b want 0", btb_we);
        end
        step();
        @(negedge clk);
        checks++;
        if (btb_we !== 1'b1) begin
            errors++;
            $display("FAIL single_we_latency got %b want 1", btb_we);
        end
        step();
        @(negedge clk);
        checks++;
        if (btb_we !== 1'b0) begin
            errors++;
            $display("FAIL single_we_pulse got %b want 0", btb_we);
        end
        step();
        wait_drain(ok);
        checks++;
        if (!ok || drop_cnt !== 16'(exp_drop)) begin
            errors++;
            $display("FAIL single_drain got pending=%0d drop=%0d want 0 %0d",
                     exp_q.size(), drop_cnt, exp_drop);
        end
    endtask

    task automatic test_filter();
        bit ok;
        drive_upd(16'h0080, 16'h0084, 16'h0084);  // correct prediction
        @(negedge clk);
        checks++;
        if (upd_ready !== 1'b1) begin
            errors++;
            $display("FAIL filter_ready got %b want 1", upd_ready);
        end
        step();
        drive_upd(16'h0082, 16'h0200, 16'h0086);  // misaligned PC
        step();
        upd_valid = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok || drop_cnt !== 16'(exp_drop) || upd_ready !== 1'b1) begin
            errors++;
            $display("FAIL filter_state got drop=%0d ready=%b want %0d 1",
                     drop_cnt, upd_ready, exp_drop);
        end
    endtask

    task automatic test_arbitration();
        bit ok;
        bit saw_full;
        bit xfer;
        int di;
        saw_full = 1'b0;
        di = 0;
        for (int i = 0; i < 7; i++) begin
            push_exp(16'h2000 + 16'(i * 4), 16'h2800 + 16'(i * 4));
            push_exp(16'h1000 + 16'(i * 4), 16'h3000 + 16'(i * 4));
        end
        push_exp(16'h201C, 16'h281C);
        for (int i = 8; i < 16; i += 2) push_exp(16'h1000 + 16'(i * 4), 16'h3000 + 16'(i * 4));
        exp_drop += 5;
        for (int c = 0; c < 16; c++) begin
            drive_upd(16'h1000 + 16'(c * 4), 16'h3000 + 16'(c * 4), 16'h1004 + 16'(c * 4));
            dbg_valid = (di < 8);
            dbg_pc    = 16'h2000 + 16'(di * 4);
            dbg_npc   = 16'h2800 + 16'(di * 4);
            @(negedge clk);
            if (!upd_ready) saw_full = 1'b1;
            xfer = dbg_valid && dbg_ready;
            step();
            if (xfer) di++;
        end
        upd_valid = 1'b0;
        dbg_valid = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL arb_drain got pending=%0d want 0", exp_q.size());
        end
        checks++;
        if (di != 8 || !saw_full) begin
            errors++;
            $display("FAIL arb_progress got dbg_done=%0d saw_full=%b want 8 1", di, saw_full);
        end
        checks++;
        if (drop_cnt !== 16'(exp_drop)) begin
            errors++;
            $display("FAIL arb_drop_cnt got %0d want %0d", drop_cnt, exp_drop);
        end
    endtask

    task automatic test_coalesce();
        bit ok;
        push_exp(16'h4000, 16'h4800);
        push_exp(16'h0500, 16'h0600);
        push_exp(16'h4004, 16'h4804);
        push_exp(16'h0100, 16'h0300);
        dbg_valid = 1'b1; dbg_pc = 16'h4000; dbg_npc = 16'h4800;
        drive_upd(16'h0500, 16'h0600, 16'h0504);
        step();
        dbg_valid = 1'b0;
        drive_upd(16'h0100, 16'h0200, 16'h0104);
        step();
        dbg_valid = 1'b1; dbg_pc = 16'h4004; dbg_npc = 16'h4804;
        drive_upd(16'h0100, 16'h0300, 16'h0104);
        @(negedge clk);
        checks++;
        if (dbg_ready !== 1'b1) begin
            errors++;
            $display("FAIL coalesce_dbg_grant got %b want 1", dbg_ready);
        end
        step();
        dbg_valid = 1'b0;
        upd_valid = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok || drop_cnt !== 16'(exp_drop)) begin
            errors++;
            $display("FAIL coalesce_state got pending=%0d drop=%0d want 0 %0d",
                     exp_q.size(), drop_cnt, exp_drop);
        end
    endtask

    task automatic test_sweep();
        bit ok;
        bit xfer;
        int di;
        int busy_n;
        di = 0;
        push_exp(16'h5000, 16'h5800);
        push_exp(16'h6000, 16'h6800);
        push_exp(16'h5004, 16'h5804);
        push_exp(16'h6004, 16'h6804);
        push_exp(16'h5008, 16'h5808);
        for (int i = 0; i < 256; i++) push_exp(16'(i * 4), 16'(i * 4 + 4));
        push_exp(16'h500C, 16'h580C);
        // Build up three queued EX entries behind the debug port.
        for (int c = 0; c < 5; c++) begin
            drive_upd(16'h6000 + 16'(c * 4), 16'h6800 + 16'(c * 4), 16'h6004 + 16'(c * 4));
            dbg_valid = (di < 3);
            dbg_pc    = 16'h5000 + 16'(di * 4);
            dbg_npc   = 16'h5800 + 16'(di * 4);
            @(negedge clk);
            xfer = dbg_valid && dbg_ready;
            step();
            if (xfer) di++;
        end
        upd_valid = 1'b0;
        sweep_req = 1'b1;
        dbg_valid = 1'b1; dbg_pc = 16'h500C; dbg_npc = 16'h580C;
        @(negedge clk);
        checks++;
        if (dbg_ready !== 1'b0 || sweep_busy !== 1'b0) begin
            errors++;
            $display("FAIL sweep_req_cycle got dbg_ready=%b busy=%b want 0 0", dbg_ready, sweep_busy);
        end
        busy_n = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!sweep_busy) break;
            busy_n++;
            sweep_req = 1'b0;
            if (n == 0) begin
                checks++;
                if (upd_ready !== 1'b0 || dbg_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_ready got upd_ready=%b dbg_ready=%b want 0 0",
                             upd_ready, dbg_ready);
                end
            end
            if (n < 10) drive_upd(16'h7000 + 16'(n * 4), 16'h7800, 16'h7004 + 16'(n * 4));
            else        upd_valid = 1'b0;
        end
        exp_drop += 10;
        checks++;
        if (busy_n != 256) begin
            errors++;
            $display("FAIL sweep_busy_len got %0d want 256", busy_n);
        end
        checks++;
        if (dbg_ready !== 1'b1) begin
            errors++;
            $display("FAIL sweep_resume got dbg_ready=%b want 1", dbg_ready);
        end
        step();
        dbg_valid = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok || drop_cnt !== 16'(exp_drop)) begin
            errors++;
            $display("FAIL sweep_state got pending=%0d drop=%0d want 0 %0d",
                     exp_q.size(), drop_cnt, exp_drop);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit ok;
        for (int i = 0; i < 18; i++) push_exp(16'(i * 4), 16'(i * 4 + 4));
        sweep_req = 1'b1;
        step();
        sweep_req = 1'b0;
        repeat (17) step();
        @(negedge clk);
        checks++;
        if (sweep_busy !== 1'b1 || btb_pc !== 16'h0044) begin
            errors++;
            $display("FAIL abort_pre got busy=%b pc=%h want 1 0044", sweep_busy, btb_pc);
        end
        #1;
        rst_n = 1'b0;
        #1;
        exp_drop = 0;
        checks++;
        if (btb_we !== 1'b0 || btb_pc !== 16'h0 || btb_npc !== 16'h0 ||
            sweep_busy !== 1'b0 || drop_cnt !== 16'h0) begin
            errors++;
            $display("FAIL abort_async got we=%b pc=%h npc=%h busy=%b drop=%0d want all 0",
                     btb_we, btb_pc, btb_npc, sweep_busy, drop_cnt);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (sweep_busy !== 1'b0 || btb_we !== 1'b0 || upd_ready !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_idle got busy=%b we=%b ready=%b pending=%0d want 0 0 1 0",
                     sweep_busy, btb_we, upd_ready, exp_q.size());
        end
        step();
        push_exp(16'h0A00, 16'h0B00);
        drive_upd(16'h0A00, 16'h0B00, 16'h0A04);
        step();
        upd_valid = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_recover got pending=%0d want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_update();
        test_filter();
        test_arbitration();
        test_coalesce();
        test_sweep();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
